// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit per cycle
// beside the EX-stage ALU. It also accepts MTHI/MTLO writes.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   start, op        EX holds a muldiv/MTHI/MTLO instruction, and its opcode
//   op_a, op_b       rs / rt operands
//   hilo_rd          EX instruction reads HI or LO
//   flush            kill any in-progress operation
//   busy, stall      unit occupied; hazard request to the pipeline
//   done             high in the one-cycle sign-fix state
//   hi, lo           architectural HI/LO registers
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;          // multiplicand magnitude
    logic [WIDTH-1:0]   b_q, b_d;          // divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;      // mul: product; div: {remainder, quotient}
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               q_bit;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

    assign op_signed = ~op[0];
    assign abs_a = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    // Shift-add: the multiplier sits in the low half and is consumed from bit 0.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: the shifted remainder needs one extra bit so that
    // divisors with the MSB set compare correctly.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign q_bit    = (rem_sh >= {1'b0, b_q});
    assign div_next = q_bit ? {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};

    // Sign correction; the most-negative / -1 case wraps naturally here.
    assign quo_raw  = acc_q[WIDTH-1:0];
    assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_raw : quo_raw;
    assign rem_fix  = sign_a_q ? -rem_raw : rem_raw;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (op == 3'b100) begin
                            hi_d = op_a;
                        end else if (op == 3'b101) begin
                            lo_d = op_a;
                        end else if (!op[2]) begin
                            is_div_d = op[1];
                            sign_a_d = op_signed & op_a[WIDTH-1];
                            sign_b_d = op_signed & op_b[WIDTH-1];
                            a_d      = abs_a;
                            b_d      = abs_b;
                            cnt_d    = CW'(WIDTH - 1);
                            acc_d    = op[1] ? {{WIDTH{1'b0}}, abs_a}
                                             : {{WIDTH{1'b0}}, abs_b};
                            div0_d   = op[1] && (op_b == '0);
                            state_d  = (op[1] && (op_b == '0)) ? S_FIX : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    state_d = S_IDLE;
                    if (!div0_q) begin
                        if (is_div_q) begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end else begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_FIX);
    assign stall = busy & (start | hilo_rd);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
